// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - krv MEM stage: data-memory access, load alignment, writeback register
//
// Takes the registered EX result, performs at most one req/ack data-memory
// transfer with byte-lane steering, aligns/extends load data and registers the
// writeback slot. Stalls EX through mem_ready while a transfer is outstanding.
//
// Ports:
//   cpu_clk, cpu_rstn            clock, asynchronous active-low reset
//   ex_valid ... store_data_mem  registered EX-stage results (held while mem_ready=0)
//   mem_ready                    MEM can accept the next EX op this cycle
//   dmem_req/we/be/addr/wdata    data bus request side
//   dmem_rdata/dmem_ack          data bus response side (zero-wait ack allowed)
//   wb_valid/we/rd/data          registered writeback slot
//   misalign_exc, bus_err        one-cycle pulses aligned with wb_valid
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              ex_valid,
  input  logic [31:0]       alu_result_mem,
  input  logic [5:0]        rd_mem,
  input  logic              load_mem,
  input  logic              store_mem,
  input  logic              mem_H_mem,
  input  logic              mem_B_mem,
  input  logic              mem_U_mem,
  input  logic [31:0]       store_data_mem,
  output logic              mem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_exc,
  output logic              bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic        mem_op;
  logic        mis;
  logic        go;
  logic        abort;
  logic [1:0]  off;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  assign off    = alu_result_mem[1:0];
  assign mem_op = ex_valid & (load_mem | store_mem);
  assign mis    = (mem_H_mem & off[0]) | (~mem_H_mem & ~mem_B_mem & (|off));
  assign go     = mem_op & ~mis;

  // Abort only when the count has expired and no ack arrives in that same
  // cycle; a coincident ack completes the access normally.
  assign abort  = (state == S_BUSY) && (cnt == CNT_W'(TIMEOUT)) && !dmem_ack;

  assign dmem_req  = go & ~abort;
  assign mem_ready = ~go | dmem_ack | abort;
  assign dmem_we   = store_mem;
  assign dmem_addr = {alu_result_mem[31:2], 2'b00};

  // Write data is replicated across lanes so the slave can pick any lane
  // selected by dmem_be without further muxing.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_mem;
    if (mem_B_mem) begin
      dmem_be    = 4'b0001 << off;
      dmem_wdata = {4{store_data_mem[7:0]}};
    end else if (mem_H_mem) begin
      dmem_be    = off[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{store_data_mem[15:0]}};
    end
  end

  assign rdata_shifted = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    if (mem_B_mem) begin
      load_data = {{24{~mem_U_mem & rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (mem_H_mem) begin
      load_data = {{16{~mem_U_mem & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

  // IDLE covers the request cycle itself; BUSY is entered only when the
  // first cycle did not see an ack, with cnt counting BUSY cycles from 1.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go && !dmem_ack) begin
            state <= S_BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (dmem_ack || abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Stall cycles insert a bubble: flags clear, rd/data simply hold.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else if (mem_ready) begin
      wb_valid     <= ex_valid;
      wb_rd        <= rd_mem[4:0];
      wb_data      <= load_mem ? load_data : alu_result_mem;
      wb_we        <= ex_valid & ~store_mem & (rd_mem != 6'd0) & (rd_mem != 6'd32)
                      & ~mis & ~abort;
      misalign_exc <= mem_op & mis;
      bus_err      <= abort;
    end else begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_result_mem = '0;
  logic [5:0]  rd_mem = '0;
  logic        load_mem = 1'b0;
  logic        store_mem = 1'b0;
  logic        mem_H_mem = 1'b0;
  logic        mem_B_mem = 1'b0;
  logic        mem_U_mem = 1'b0;
  logic [31:0] store_data_mem = '0;
  logic        mem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .ex_valid(ex_valid),
    .alu_result_mem(alu_result_mem), .rd_mem(rd_mem), .load_mem(load_mem),
    .store_mem(store_mem), .mem_H_mem(mem_H_mem), .mem_B_mem(mem_B_mem),
    .mem_U_mem(mem_U_mem), .store_data_mem(store_data_mem), .mem_ready(mem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: one op presented to MEM, bus slave acks after `delay` wait
  // cycles (delay > TO means the slave never answers in time).
  task automatic run_op(input logic v, input logic ld, input logic st, input logic h,
                        input logic b, input logic u, input logic [31:0] addr,
                        input logic [5:0] rd, input logic [31:0] sd,
                        input logic [31:0] rdat, input int delay);
    int unsigned off, x, e_be, e_wd, e_data;
    bit mop, mis, go, aborted, now_abort, ackv, done, e_we;
    int k;
    off = addr % 4;
    mop = v && (ld || st);
    mis = h ? (off % 2 == 1) : (!b && off != 0);
    go  = mop && !mis;
    if (b)      begin e_be = 1 << off;              e_wd = (sd & 8'hFF) * 32'h01010101; end
    else if (h) begin e_be = (off >= 2) ? 12 : 3;   e_wd = (sd & 16'hFFFF) * 32'h00010001; end
    else        begin e_be = 15;                    e_wd = sd; end
    x = rdat >> (8 * off);
    if (b)      begin x = x & 32'hFF;   if (!u && x >= 32'h80)   x = x | 32'hFFFFFF00; end
    else if (h) begin x = x & 32'hFFFF; if (!u && x >= 32'h8000) x = x | 32'hFFFF0000; end
    e_data = ld ? x : addr;

    @(negedge cpu_clk);
    ex_valid = v; load_mem = ld; store_mem = st; mem_H_mem = h; mem_B_mem = b;
    mem_U_mem = u; alu_result_mem = addr; rd_mem = rd; store_data_mem = sd;
    aborted = 0;
    if (go) begin
      done = 0;
      k = 0;
      while (!done) begin
        if (k > 0) @(negedge cpu_clk);
        ackv = (k == delay);
        now_abort = !ackv && (k == TO);
        dmem_ack = ackv;
        dmem_rdata = ackv ? rdat : $urandom;
        #1;
        chk("req", 32'(dmem_req), 32'(!now_abort));
        chk("ready", 32'(mem_ready), 32'(ackv || now_abort));
        if (!now_abort) begin
          chk("addr", dmem_addr, addr & 32'hFFFFFFFC);
          chk("we", 32'(dmem_we), 32'(st));
          chk("be", 32'(dmem_be), e_be);
          if (st) chk("wdata", dmem_wdata, e_wd);
        end
        done = ackv || now_abort;
        aborted = now_abort;
        @(posedge cpu_clk); #1;
        if (!done) chk("stall_wbv", 32'(wb_valid), 0);
        k++;
      end
    end else begin
      dmem_ack = 1'($urandom % 2);
      dmem_rdata = $urandom;
      #1;
      chk("idle_req", 32'(dmem_req), 0);
      chk("idle_ready", 32'(mem_ready), 1);
      @(posedge cpu_clk); #1;
    end
    e_we = v && !st && rd != 0 && rd != 32 && !mis && !aborted;
    chk("wb_valid", 32'(wb_valid), 32'(v));
    chk("wb_we", 32'(wb_we), 32'(e_we));
    chk("misalign", 32'(misalign_exc), 32'(mop && mis));
    chk("bus_err", 32'(bus_err), 32'(aborted));
    chk("wb_rd", 32'(wb_rd), 32'(rd % 32));
    if (v && !mis && !aborted) chk("wb_data", wb_data, e_data);
  endtask

  initial begin
    int sz, kind, dly;
    logic [31:0] a;
    cpu_rstn = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_rd", 32'(wb_rd), 0);
    chk("rst_data", wb_data, 0);
    chk("rst_mis", 32'(misalign_exc), 0);
    chk("rst_berr", 32'(bus_err), 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // Directed cases
    run_op(1, 1, 0, 0, 1, 0, 32'h00001003, 6'd7, 32'h0, 32'h80112233, 0);  // lb
    chk("lb_data", wb_data, 32'hFFFFFF80);
    run_op(1, 0, 1, 1, 0, 0, 32'h00002002, 6'd9, 32'h1234ABCD, 32'h0, 1);  // sh
    run_op(1, 1, 0, 0, 0, 0, 32'h00000100, 6'd3, 32'h0, 32'hCAFEF00D, 3);  // lw wait 3
    chk("lw_data", wb_data, 32'hCAFEF00D);
    run_op(1, 1, 0, 1, 0, 1, 32'h00000101, 6'd4, 32'h0, 32'h0, 0);         // lhu misaligned
    run_op(1, 1, 0, 0, 0, 0, 32'h00000200, 6'd6, 32'h0, 32'h0, 99);        // timeout
    run_op(1, 1, 0, 1, 0, 0, 32'h00000302, 6'd8, 32'h0, 32'h9ABC1234, TO); // ack at timeout
    chk("ack_wins", wb_data, 32'hFFFF9ABC);
    run_op(1, 0, 0, 0, 0, 0, 32'h00000055, 6'd5, 32'h0, 32'h0, 0);
    chk("alu_data", wb_data, 32'h55);
    run_op(1, 0, 0, 0, 0, 0, 32'h00000055, 6'd0, 32'h0, 32'h0, 0);
    run_op(1, 0, 0, 0, 0, 0, 32'h00000055, 6'd32, 32'h0, 32'h0, 0);

    // Reset during BUSY: outputs clear asynchronously, next access starts fresh
    run_op(1, 0, 0, 0, 0, 0, 32'h00000077, 6'd5, 32'h0, 32'h0, 0);
    @(negedge cpu_clk);
    ex_valid = 1; load_mem = 1; store_mem = 0; mem_H_mem = 0; mem_B_mem = 0;
    alu_result_mem = 32'h400; dmem_ack = 0;
    repeat (2) @(negedge cpu_clk);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("arst_rd", 32'(wb_rd), 0);
    chk("arst_data", wb_data, 0);
    ex_valid = 0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    run_op(1, 1, 0, 0, 0, 0, 32'h00000400, 6'd2, 32'h0, 32'h13572468, TO);
    chk("post_rst_lw", wb_data, 32'h13572468);

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      kind = $urandom % 4;
      sz = $urandom % 3;
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = (sz == 0) ? 2'b00 : ((sz == 1) ? {1'($urandom), 1'b0} : 2'($urandom));
      dly = ($urandom % 4 == 0) ? TO + 1 + ($urandom % 3) : int'($urandom % (TO + 1));
      run_op(kind != 3, kind == 1, kind == 2, sz == 1, sz == 2, 1'($urandom),
             a, ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 6'd0 : 6'd32) : 6'($urandom),
             $urandom, $urandom, dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
